// File: rtl/disp_seq_scan_if.sv
// Display pin bundle between the sequence checker side and the digit scanner.
interface disp_seq_scan_if;
  logic [31:0] DISP_SEQ;
  logic [7:0]  DISP_OFF;
  logic [7:0]  AN_N;
  logic [6:0]  SEG_N;
  logic        FRAME;

  modport master (output DISP_SEQ, DISP_OFF, input AN_N, SEG_N, FRAME);
  modport slave  (input DISP_SEQ, DISP_OFF, output AN_N, SEG_N, FRAME);
endinterface

// File: rtl/disp_seq_scan.sv
// 8-digit common-anode 7-segment scanner: hex decode, per-digit blanking,
// anti-ghost dead time and a once-per-frame input snapshot.
module disp_seq_scan #(
  parameter int DIV  = 1000,
  parameter int DEAD = 16
) (
  input logic            CLK,
  input logic            RST,
  disp_seq_scan_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] dcnt;
  logic [2:0]    idx;
  logic          init;
  logic [31:0]   seq_l;
  logic [7:0]    off_l;
  logic [7:0]    an_n;
  logic [6:0]    seg_n;
  logic          frame;

  logic       tick, snap, in_dead, lit;
  logic [3:0] nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // A zero dead time must not produce a constant unsigned compare.
  generate
    if (DEAD == 0) begin : g_no_dead
      assign in_dead = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
      assign in_dead = (dcnt < DEAD_C);
    end
  endgenerate

  assign tick = (dcnt == LAST);
  // Capture only at the frame boundary so a frame never mixes two words.
  assign snap = init | (tick & (idx == 3'd7));
  assign nib  = seq_l[{idx, 2'b00} +: 4];
  assign lit  = !in_dead && !off_l[idx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      dcnt  <= '0;
      idx   <= 3'd0;
      init  <= 1'b1;
      seq_l <= 32'h0;
      off_l <= 8'hFF;
      an_n  <= 8'hFF;
      seg_n <= 7'h7F;
      frame <= 1'b0;
    end else begin
      dcnt <= tick ? '0 : dcnt + 1'b1;
      if (tick) idx <= idx + 3'd1;
      if (snap) begin
        seq_l <= bus.DISP_SEQ;
        off_l <= bus.DISP_OFF;
        init  <= 1'b0;
      end
      frame <= snap;
      an_n  <= lit ? ~(8'b1 << idx) : 8'hFF;
      seg_n <= lit ? ~hex7(nib) : 7'h7F;
    end
  end

  assign bus.AN_N  = an_n;
  assign bus.SEG_N = seg_n;
  assign bus.FRAME = frame;
endmodule

// File: tb/tb_disp_seq_scan.sv
// Scoreboard bench for disp_seq_scan: a DIV=4/DEAD=1 instance and a DIV=2/DEAD=0 instance.
module tb_disp_seq_scan;
  localparam int DIV_A = 4, DEAD_A = 1, DIV_B = 2, DEAD_B = 0;
  localparam logic [6:0] HEX_T [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [6:0] EXP_LO [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [6:0] EXP_HI [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed { logic [7:0] an; logic [6:0] seg; logic fr; } exp_t;

  logic CLK = 1'b0;
  logic rst_a, rst_b;
  disp_seq_scan_if bus_a();
  disp_seq_scan_if bus_b();

  disp_seq_scan #(.DIV(DIV_A), .DEAD(DEAD_A)) dut_a (.CLK(CLK), .RST(rst_a), .bus(bus_a.slave));
  disp_seq_scan #(.DIV(DIV_B), .DEAD(DEAD_B)) dut_b (.CLK(CLK), .RST(rst_b), .bus(bus_b.slave));

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  exp_t sb_a[$], sb_b[$];
  int          mk   [2];
  logic [31:0] mseq [2];
  logic [7:0]  moff [2];
  logic [7:0]  obs_an  [2];
  logic [6:0]  obs_seg [2];
  logic        obs_fr  [2];
  int          lit_cnt [8];
  logic [6:0]  seg_seen[8];
  logic        seg_var [8];
  int          frames;

  // k = cycles since reset release; the output after this edge reflects slot k.
  function automatic exp_t predict(int div, int dead, int k, logic [31:0] s, logic [7:0] o);
    exp_t e;
    int d, i;
    d = k % div;
    i = (k / div) % 8;
    if (d >= dead && !o[i]) begin
      e.an  = ~(8'd1 << i);
      e.seg = ~HEX_T[s[i*4 +: 4]];
    end else begin
      e.an  = 8'hFF;
      e.seg = 7'h7F;
    end
    e.fr = (k == 0) || (k % (8*div) == 8*div - 1);
    return e;
  endfunction

  task automatic cycle();
    exp_t e, act;
    if (rst_a) begin
      e = '{8'hFF, 7'h7F, 1'b0}; mk[0] = 0; mseq[0] = 32'h0; moff[0] = 8'hFF;
    end else begin
      e = predict(DIV_A, DEAD_A, mk[0], mseq[0], moff[0]);
      if (e.fr) begin mseq[0] = bus_a.DISP_SEQ; moff[0] = bus_a.DISP_OFF; end
      mk[0]++;
    end
    sb_a.push_back(e);
    if (rst_b) begin
      e = '{8'hFF, 7'h7F, 1'b0}; mk[1] = 0; mseq[1] = 32'h0; moff[1] = 8'hFF;
    end else begin
      e = predict(DIV_B, DEAD_B, mk[1], mseq[1], moff[1]);
      if (e.fr) begin mseq[1] = bus_b.DISP_SEQ; moff[1] = bus_b.DISP_OFF; end
      mk[1]++;
    end
    sb_b.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    e = sb_a.pop_front();
    act = '{bus_a.AN_N, bus_a.SEG_N, bus_a.FRAME};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL sb_a t=%0t an/seg/fr got %h/%h/%b want %h/%h/%b", $time, act.an, act.seg, act.fr, e.an, e.seg, e.fr);
    end
    e = sb_b.pop_front();
    act = '{bus_b.AN_N, bus_b.SEG_N, bus_b.FRAME};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL sb_b t=%0t an/seg/fr got %h/%h/%b want %h/%h/%b", $time, act.an, act.seg, act.fr, e.an, e.seg, e.fr);
    end
    checks++;
    if ($countones(~bus_a.AN_N) > 1 || $countones(~bus_b.AN_N) > 1) begin
      failures++;
      $display("FAIL onehot_an t=%0t got a=%h b=%h want at most one low bit", $time, bus_a.AN_N, bus_b.AN_N);
    end
    obs_an[0] = bus_a.AN_N; obs_seg[0] = bus_a.SEG_N; obs_fr[0] = bus_a.FRAME;
    obs_an[1] = bus_b.AN_N; obs_seg[1] = bus_b.SEG_N; obs_fr[1] = bus_b.FRAME;
  endtask

  task automatic wait_frame(input int which);
    logic got = 1'b0;
    for (int n = 0; n < 80 && !got; n++) begin
      cycle();
      if (obs_fr[which]) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL frame_timeout dut=%0d got no FRAME want FRAME within 80 cycles", which);
    end
  endtask

  // One full frame of dut_a right after a FRAME pulse.
  task automatic collect_frame();
    frames = 0;
    for (int j = 0; j < 8; j++) begin lit_cnt[j] = 0; seg_seen[j] = 7'h7F; seg_var[j] = 1'b0; end
    for (int n = 0; n < 8*DIV_A; n++) begin
      cycle();
      if (obs_fr[0]) frames++;
      for (int j = 0; j < 8; j++)
        if (obs_an[0] == ~(8'd1 << j)) begin
          lit_cnt[j]++;
          if (lit_cnt[j] == 1) seg_seen[j] = obs_seg[0];
          else if (seg_seen[j] != obs_seg[0]) seg_var[j] = 1'b1;
        end
    end
  endtask

  task automatic test_reset();
    int lit0 = 0, other = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.DISP_SEQ = 32'h0000_0002; bus_a.DISP_OFF = 8'hFE;
    bus_b.DISP_SEQ = 32'h0; bus_b.DISP_OFF = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      cycle();
      checks++;
      if (obs_an[0] !== 8'hFF || obs_seg[0] !== 7'h7F) begin
        failures++;
        $display("FAIL reset_outputs got an=%h seg=%h want an=ff seg=7f", obs_an[0], obs_seg[0]);
      end
    end
    rst_a = 1'b0; rst_b = 1'b0;
    cycle();
    checks++;
    if (obs_fr[0] !== 1'b1) begin
      failures++;
      $display("FAIL first_frame got FRAME=%b want 1", obs_fr[0]);
    end
    for (int n = 0; n < 63; n++) begin
      cycle();
      if (obs_an[0] == 8'hFE && obs_seg[0] == 7'h24) lit0++;
      else if (obs_an[0] != 8'hFF) other++;
    end
    checks++;
    if (lit0 != 6 || other != 0) begin
      failures++;
      $display("FAIL blank_mask got lit0=%0d other=%0d want lit0=6 other=0", lit0, other);
    end
  endtask

  task automatic test_full_scan();
    bus_a.DISP_SEQ = 32'h7654_3210; bus_a.DISP_OFF = 8'h00;
    wait_frame(0);
    collect_frame();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (lit_cnt[j] != 3 || seg_seen[j] !== EXP_LO[j] || seg_var[j]) begin
        failures++;
        $display("FAIL full_scan d%0d got lit=%0d seg=%h want lit=3 seg=%h", j, lit_cnt[j], seg_seen[j], EXP_LO[j]);
      end
    end
    checks++;
    if (frames != 1) begin
      failures++;
      $display("FAIL frame_period got frames=%0d want 1 per 32 cycles", frames);
    end
  endtask

  task automatic test_frame_sync();
    logic got = 1'b0;
    bus_a.DISP_SEQ = 32'h1111_1111;
    wait_frame(0);
    for (int n = 0; n < 13; n++) cycle();
    bus_a.DISP_SEQ = 32'h2222_2222;
    for (int n = 0; n < 40 && !got; n++) begin
      cycle();
      if (obs_fr[0]) got = 1'b1;
      checks++;
      if (obs_an[0] != 8'hFF && obs_seg[0] !== 7'h79) begin
        failures++;
        $display("FAIL frame_sync_old an=%h got seg=%h want 79", obs_an[0], obs_seg[0]);
      end
    end
    checks++;
    if (!got) begin failures++; $display("FAIL frame_sync_timeout got no FRAME want FRAME"); end
    for (int n = 0; n < 32; n++) begin
      cycle();
      checks++;
      if (obs_an[0] != 8'hFF && obs_seg[0] !== 7'h24) begin
        failures++;
        $display("FAIL frame_sync_new an=%h got seg=%h want 24", obs_an[0], obs_seg[0]);
      end
    end
  endtask

  task automatic test_dead_zero();
    bus_b.DISP_SEQ = 32'h7654_3210; bus_b.DISP_OFF = 8'h00;
    wait_frame(1);
    for (int n = 0; n < 16; n++) begin
      cycle();
      checks++;
      if (obs_an[1] === 8'hFF) begin
        failures++;
        $display("FAIL dead_zero_gap got an=ff want a lit digit every cycle");
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 40 && !(mk[0] % 4 == 2 && (mk[0] / 4) % 8 == 5); n++) cycle();
    checks++;
    if (dut_a.idx !== 3'd5 || dut_a.dcnt !== 2'd2) begin
      failures++;
      $display("FAIL mid_pos got idx=%0d dcnt=%0d want idx=5 dcnt=2", dut_a.idx, dut_a.dcnt);
    end
    rst_a = 1'b1;
    cycle();
    checks++;
    if (dut_a.idx !== 3'd0 || dut_a.dcnt !== 2'd0 || dut_a.off_l !== 8'hFF || obs_an[0] !== 8'hFF) begin
      failures++;
      $display("FAIL mid_reset got idx=%0d dcnt=%0d off=%h an=%h want 0/0/ff/ff",
               dut_a.idx, dut_a.dcnt, dut_a.off_l, obs_an[0]);
    end
    rst_a = 1'b0;
    cycle();
    checks++;
    if (obs_fr[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_recapture got FRAME=%b want 1", obs_fr[0]);
    end
  endtask

  task automatic test_hex();
    bus_a.DISP_SEQ = 32'hFEDC_BA98; bus_a.DISP_OFF = 8'h00;
    wait_frame(0);
    collect_frame();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (seg_seen[j] !== EXP_HI[j] || lit_cnt[j] != 3) begin
        failures++;
        $display("FAIL hex_hi d%0d got seg=%h lit=%0d want seg=%h lit=3", j, seg_seen[j], lit_cnt[j], EXP_HI[j]);
      end
    end
    bus_a.DISP_SEQ = 32'h7654_3210;
    for (int b = 0; b < 8; b++) begin
      bus_a.DISP_OFF = 8'd1 << b;
      wait_frame(0);
      collect_frame();
      checks++;
      if (lit_cnt[b] != 0 || lit_cnt[(b+1)%8] != 3 || seg_seen[(b+1)%8] !== EXP_LO[(b+1)%8]) begin
        failures++;
        $display("FAIL walk_off b%0d got lit=%0d next_lit=%0d want 0 and 3", b, lit_cnt[b], lit_cnt[(b+1)%8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_frame_sync();
    test_dead_zero();
    test_reset_mid();
    test_hex();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/disp_seq_scan.md
Name: disp_seq_scan

Overview:
- Display back-end for the sequence-logic trainer. Sits directly downstream of the sequence checker.
- Consumes the checker's 8-nibble display word DISP_SEQ and the per-digit blank mask DISP_OFF.
- Time-multiplexes them onto an 8-digit common-anode 7-segment display, with hex decoding, per-digit blanking, anti-ghosting dead time and frame-synchronous input capture.

Parameters:
- DIV, 1000: clock cycles each digit is selected; legal range 2..65535.
- DEAD, 16: cycles at the start of each digit slot with all anodes off; legal range 0..DIV-1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- DISP_SEQ  in  32  eight hex digits; digit i = DISP_SEQ[4i+3:4i]; digit 7 is leftmost.
- DISP_OFF  in  8  bit i = 1 blanks digit i.
- AN_N  out  8  anode selects, active-low; bit i drives digit i.
- SEG_N  out  7  segments {g,f,e,d,c,b,a}, active-low.
- FRAME  out  1  one-cycle pulse when a new input snapshot is taken.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST. All state is updated on posedge CLK only.
- Reset values:
  - DCNT = 0, IDX = 0, INIT = 1.
  - SEQ_L = 32'h0, OFF_L = 8'hFF.
  - AN_N = 8'hFF, SEG_N = 7'h7F, FRAME = 0.
- RST has priority over every other event, including when asserted mid-slot or mid-frame.
- Prescaler DCNT counts 0..DIV-1 and wraps. TICK = (DCNT == DIV-1).
- On TICK, IDX (3 bits) increments; it wraps 7 -> 0.
- Snapshot: SEQ_L <= DISP_SEQ and OFF_L <= DISP_OFF, with FRAME = 1 for that cycle, when either:
  - (TICK and IDX == 7), or
  - INIT == 1; INIT then clears.
  - The first capture therefore happens on the first cycle after RST deasserts.
- Input changes between snapshots are ignored, so the display shows no tearing.
- Registered outputs, computed from the current DCNT, IDX, SEQ_L and OFF_L; they appear one cycle later:
  - Dead window (DCNT < DEAD): AN_N = 8'hFF, SEG_N = 7'h7F.
  - Digit blanked (OFF_L[IDX] == 1): AN_N = 8'hFF, SEG_N = 7'h7F.
  - Otherwise: AN_N = ~(8'b1 << IDX), SEG_N = ~HEX(SEQ_L[4*IDX+3 -: 4]).
- HEX table, active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Invariant: at most one AN_N bit is low in any cycle.
- Timing:
  - Full frame = 8*DIV cycles.
  - Each digit is lit for DIV-DEAD cycles per frame.
  - With DEAD = 0, the anode switches directly from one digit to the next.
- Latency:
  - Input to capture: up to 8*DIV cycles (next frame boundary).
  - Capture to pins: 1 cycle.
- Width rule: DCNT width = clog2(DIV). No other arithmetic.

Test Plan:
1. Reset and blanking. DIV=4, DEAD=1; hold RST 3 cycles, then DISP_SEQ=32'h0000_0002, DISP_OFF=8'hFE.
   - During RST: AN_N=FF, SEG_N=7F.
   - FRAME pulses on the 1st cycle after release.
   - Digit 0 shows AN_N=FE, SEG_N=~5B=24 for 3 cycles of every 32; all other slots stay AN_N=FF.
2. Full scan. DISP_SEQ=32'h7654_3210, DISP_OFF=00, DIV=4, DEAD=1.
   - Anodes step FE,FD,FB,...,7F, each lit 3 cycles after a 1-cycle all-off gap.
   - SEG_N per digit: 40,79,24,30,19,12,02,78.
   - FRAME every 32 cycles.
3. Frame sync. Change DISP_SEQ from 32'h1111_1111 to 32'h2222_2222 while IDX=3.
   - Digits 4..7 still show ~06=79 for the rest of the frame.
   - All digits show 24 only after the next FRAME.
4. Dead-time edge. DEAD=0, DIV=2.
   - No cycle with AN_N=FF between lit digits.
   - Never more than one AN_N bit low.
5. Reset mid-frame. Assert RST at IDX=5, DCNT=2.
   - Next cycle: IDX=0, DCNT=0, AN_N=FF, OFF_L=FF.
   - On release, immediate re-capture with FRAME=1.
6. Hex coverage. Set DISP_SEQ=32'hFEDC_BA98, then 32'h7654_3210.
   - All 16 SEG_N codes match the table.
   - Check every blank-mask bit individually with a walking-one DISP_OFF.
